// File: rtl/data_bus_bridge_if.sv
// Request/response bus between the data bridge (master) and the memory-side fabric (slave).
interface data_bus_bridge_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_write;
    logic [3:0]  bus_req_wstrb;
    logic [1:0]  bus_req_size;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;
    logic        bus_resp_ready;

    modport master (
        output bus_req_valid, bus_req_write, bus_req_wstrb, bus_req_size,
               bus_req_addr, bus_req_wdata, bus_resp_ready,
        input  bus_req_ready, bus_resp_valid, bus_resp_rdata
    );

    modport slave (
        input  bus_req_valid, bus_req_write, bus_req_wstrb, bus_req_size,
               bus_req_addr, bus_req_wdata, bus_resp_ready,
        output bus_req_ready, bus_resp_valid, bus_resp_rdata
    );
endinterface

// File: rtl/data_bus_bridge.sv
// Turns the core's single-cycle SRAM-style data access into one outstanding
// valid/ready bus transaction, stalling the core until it completes or times out.
module data_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_en,
    input  logic [3:0]            cpu_wen,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stallreq,
    data_bus_bridge_if.master     bus,
    output logic                  bus_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state_reg,   state_next;
    logic [3:0]        wen_reg,     wen_next;
    logic [1:0]        size_reg,    size_next;
    logic [31:0]       addr_reg,    addr_next;
    logic [31:0]       wdata_reg,   wdata_next;
    logic [CNT_W-1:0]  cnt_reg,     cnt_next;
    logic [31:0]       rdata_reg,   rdata_next;
    logic              timeout_reg, timeout_next;
    logic [1:0]        size_decode;

    // Half-word only for aligned lane pairs; irregular masks fall back to word size.
    always_comb begin
        size_decode = 2'd2;
        case (cpu_wen)
            4'b0011, 4'b1100:                   size_decode = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_decode = 2'd0;
            default:                            size_decode = 2'd2;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            wen_reg     <= 4'd0;
            size_reg    <= 2'd0;
            addr_reg    <= 32'd0;
            wdata_reg   <= 32'd0;
            cnt_reg     <= '0;
            rdata_reg   <= 32'd0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wen_reg     <= wen_next;
            size_reg    <= size_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            cnt_reg     <= cnt_next;
            rdata_reg   <= rdata_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        wen_next     = wen_reg;
        size_next    = size_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        cnt_next     = cnt_reg;
        rdata_next   = rdata_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            IDLE: begin
                if (cpu_en) begin
                    wen_next   = cpu_wen;
                    size_next  = size_decode;
                    addr_next  = cpu_addr;
                    wdata_next = cpu_wdata;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.bus_req_ready) begin
                    cnt_next   = '0;
                    state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                cnt_next = cnt_reg + CNT_W'(1);
                // A response arriving on the final count beats the timeout.
                if (bus.bus_resp_valid) begin
                    if (wen_reg == 4'd0) begin
                        rdata_next = bus.bus_resp_rdata;
                    end
                    state_next = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    timeout_next = 1'b1;
                    if (wen_reg == 4'd0) begin
                        rdata_next = TIMEOUT_RDATA;
                    end
                    state_next = DONE;
                end
            end
            DONE: begin
                // The core still shows the finished request here, so cpu_en is not a new access.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cpu_stallreq       = ((state_reg == IDLE) && cpu_en) ||
                                (state_reg == REQ) || (state_reg == WAIT_RESP);
    assign cpu_rdata          = rdata_reg;
    assign bus_timeout        = timeout_reg;
    assign bus.bus_req_valid  = (state_reg == REQ);
    assign bus.bus_req_write  = |wen_reg;
    assign bus.bus_req_wstrb  = wen_reg;
    assign bus.bus_req_size   = size_reg;
    assign bus.bus_req_addr   = addr_reg;
    assign bus.bus_req_wdata  = wdata_reg;
    assign bus.bus_resp_ready = (state_reg == WAIT_RESP);

endmodule

// File: tb/tb_data_bus_bridge.sv
// Randomised bench for data_bus_bridge: a scripted bus slave plus a transaction-level model.
module tb_data_bus_bridge;

    localparam int T = 4;
    localparam logic [31:0] TO_DATA = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_en = 1'b0;
    logic [3:0]  cpu_wen = 4'd0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_stallreq;
    logic        bus_timeout;

    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_to = 1'b0;

    data_bus_bridge_if bus();

    data_bus_bridge #(
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_RDATA  (TO_DATA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_en       (cpu_en),
        .cpu_wen      (cpu_wen),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stallreq (cpu_stallreq),
        .bus          (bus),
        .bus_timeout  (bus_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && bus.bus_req_valid && bus.bus_req_ready) hs_count++;
    end

    function automatic logic [1:0] exp_size(input logic [3:0] w);
        if (w == 4'b0011 || w == 4'b1100) return 2'd1;
        if ($countones(w) == 1) return 2'd0;
        return 2'd2;
    endfunction

    // Expects to be entered just after a falling edge with the bridge idle.
    task automatic run_txn(input string name, input logic [3:0] wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd,
                           input int d_r, input int d_p, input bit hold_en);
        bit         is_to;
        bit         done;
        int         exp_wait, exp_stall, stall_n, req_n, wait_n, n;
        logic [1:0] exp_sz;
        is_to     = (d_p >= T);
        exp_wait  = is_to ? T : d_p + 1;
        exp_stall = d_r + exp_wait + 2;
        exp_sz    = exp_size(wen);
        if (wen == 4'd0) exp_rdata = is_to ? TO_DATA : rd;
        if (is_to) exp_to = 1'b1;
        cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
        stall_n = 0; req_n = 0; wait_n = 0; n = 0; done = 1'b0;
        while (!done && n < 200) begin
            #1;
            if (cpu_stallreq) stall_n++;
            else done = 1'b1;
            if (bus.bus_req_valid) begin
                req_n++;
                checks++;
                if (bus.bus_req_write !== (wen != 4'd0) || bus.bus_req_wstrb !== wen ||
                    bus.bus_req_size !== exp_sz || bus.bus_req_addr !== addr ||
                    bus.bus_req_wdata !== wdata) begin
                    errors++;
                    $display("FAIL %s req_fields got w=%b s=%b sz=%0d a=%h d=%h want w=%b s=%b sz=%0d a=%h d=%h",
                             name, bus.bus_req_write, bus.bus_req_wstrb, bus.bus_req_size,
                             bus.bus_req_addr, bus.bus_req_wdata, (wen != 4'd0), wen, exp_sz, addr, wdata);
                end
                bus.bus_req_ready = (req_n > d_r);
            end else begin
                bus.bus_req_ready = 1'($urandom_range(1, 0));
            end
            if (bus.bus_resp_ready) begin
                wait_n++;
                bus.bus_resp_valid = (wait_n > d_p);
                bus.bus_resp_rdata = rd;
            end else begin
                bus.bus_resp_valid = 1'($urandom_range(1, 0));
                bus.bus_resp_rdata = $urandom;
            end
            if (done) begin
                checks++;
                if (cpu_rdata !== exp_rdata || bus_timeout !== exp_to || bus.bus_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_state got rdata=%h to=%b valid=%b want rdata=%h to=%b valid=0",
                             name, cpu_rdata, bus_timeout, bus.bus_req_valid, exp_rdata, exp_to);
                end
                cpu_en = hold_en;
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s completion got timeout_of_bench want done", name);
        end
        checks++;
        if (stall_n != exp_stall || req_n != d_r + 1 || wait_n != exp_wait) begin
            errors++;
            $display("FAIL %s timing got stall=%0d req=%0d wait=%0d want stall=%0d req=%0d wait=%0d",
                     name, stall_n, req_n, wait_n, exp_stall, d_r + 1, exp_wait);
        end
        $display("txn %s wen=%b addr=%h stall=%0d req=%0d wait=%0d rdata=%h to=%b",
                 name, wen, addr, stall_n, req_n, wait_n, cpu_rdata, bus_timeout);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (cpu_rdata !== 32'd0 || cpu_stallreq !== 1'b0 || bus.bus_req_valid !== 1'b0 ||
            bus.bus_req_write !== 1'b0 || bus.bus_req_wstrb !== 4'd0 || bus.bus_req_size !== 2'd0 ||
            bus.bus_req_addr !== 32'd0 || bus.bus_req_wdata !== 32'd0 ||
            bus.bus_resp_ready !== 1'b0 || bus_timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs_zero got rdata=%h stall=%b v=%b w=%b s=%b sz=%0d a=%h d=%h rr=%b to=%b want all 0",
                     name, cpu_rdata, cpu_stallreq, bus.bus_req_valid, bus.bus_req_write,
                     bus.bus_req_wstrb, bus.bus_req_size, bus.bus_req_addr, bus.bus_req_wdata,
                     bus.bus_resp_ready, bus_timeout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; cpu_en = 1'b0;
        bus.bus_req_ready = 1'b1; bus.bus_resp_valid = 1'b1; bus.bus_resp_rdata = 32'h55AA55AA;
        repeat (3) @(negedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_read();
        run_txn("read_basic", 4'b0000, 32'h0000_1000, 32'd0, 32'h1234_5678, 0, 0, 1'b0);
        #1;
        checks++;
        if (cpu_rdata !== 32'h1234_5678 || cpu_stallreq !== 1'b0) begin
            errors++;
            $display("FAIL read_hold got rdata=%h stall=%b want rdata=12345678 stall=0", cpu_rdata, cpu_stallreq);
        end
        @(negedge clk);
    endtask

    task automatic test_write();
        run_txn("write_half", 4'b1100, 32'h0000_2002, 32'hAABB_0000, 32'hFFFF_FFFF, 0, 1, 1'b0);
    endtask

    task automatic test_ready_stall();
        run_txn("ready_wait5", 4'b1111, 32'h0000_3000, 32'hCAFE_F00D, 32'd0, 5, 0, 1'b0);
    endtask

    task automatic test_resp_at_limit();
        run_txn("resp_last_cycle", 4'b0000, 32'h0000_4000, 32'd0, 32'h0BAD_F00D, 0, T - 1, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn("read_timeout", 4'b0000, 32'h0000_5000, 32'd0, 32'h1111_1111, 1, 1000, 1'b0);
        run_txn("read_after_to", 4'b0000, 32'h0000_5004, 32'd0, 32'h2222_2222, 0, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        int hs_start;
        hs_start = hs_count;
        run_txn("b2b_first", 4'b0000, 32'h0000_6000, 32'd0, 32'h3333_4444, 0, 0, 1'b1);
        run_txn("b2b_second", 4'b0001, 32'h0000_6100, 32'h0000_0077, 32'd0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (hs_count - hs_start != 2) begin
            errors++;
            $display("FAIL b2b_request_count got %0d want 2", hs_count - hs_start);
        end
    endtask

    task automatic test_random();
        logic [3:0] wl [9];
        logic [3:0] wen;
        wl = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0101};
        for (int i = 0; i < 24; i++) begin
            wen = (i % 5 == 4) ? 4'($urandom) : wl[$urandom_range(8, 0)];
            run_txn("random", wen, $urandom, $urandom, $urandom,
                    $urandom_range(3, 0), $urandom_range(T + 1, 0), 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h0000_7000;
        bus.bus_req_ready = 1'b1; bus.bus_resp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.bus_resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_reach_wait got resp_ready=%b want 1", bus.bus_resp_ready);
        end
        rst = 1'b0; cpu_en = 1'b0;
        #1 check_zero("reset_mid");
        @(negedge clk);
        rst = 1'b1;
        bus.bus_resp_valid = 1'b1; bus.bus_resp_rdata = 32'h9999_8888;
        exp_rdata = 32'd0; exp_to = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check_zero("late_resp_ignored");
        end
        $display("txn reset_mid late response held for 4 cycles");
        @(negedge clk);
        run_txn("read_after_rst", 4'b0000, 32'h0000_7004, 32'd0, 32'h4567_89AB, 0, 0, 1'b0);
    endtask

    initial begin
        bus.bus_req_ready = 1'b0; bus.bus_resp_valid = 1'b0; bus.bus_resp_rdata = 32'd0;
        test_reset();
        test_read();
        test_write();
        test_ready_stall();
        test_resp_at_limit();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
